// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Optional REGFILE_BYPASS_EN macro enables write-through forwarding.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

    localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, set wins.
// With REGFILE_BYPASS_EN a same-cycle clear hides the pending bit from decode.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int NRP      = 2,
    parameter int NWP      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NRP*AW-1:0] rs,
    input  logic [NWP-1:0]  wb_clr,
    input  logic [NWP*AW-1:0] rd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic [NRP-1:0]  rs_busy,
    output logic            any_busy
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [NREGS-1:0] set_v;
    logic [NREGS-1:0] clr_v;

    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int r = 0; r < NREGS; r++) begin
            set_v[r] = iss_valid && (iss_rd == AW'(r));
            for (int j = 0; j < NWP; j++) begin
                if (wb_clr[j] && (rd[j*AW +: AW] == AW'(r))) begin
                    clr_v[r] = 1'b1;
                end
            end
        end
        // the issuing instruction is younger than the retiring one
        pend_d = set_v | (pend_q & ~clr_v);
        if (ZERO_REG != 0) begin
            pend_d[AW'(ZERO_ADDR)] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rs_busy = '0;
        for (int k = 0; k < NRP; k++) begin
            rs_busy[k] = pend_q[rs[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            if (clr_v[rs[k*AW +: AW]] && !set_v[rs[k*AW +: AW]]) begin
                rs_busy[k] = 1'b0;
            end
`endif
        end
    end

    assign any_busy = |pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: async reads, sync writes, pending scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRP      = 2,
    parameter int NWP      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRP*$clog2(NREGS)-1:0] rs,
    output logic [NRP*XLEN-1:0]  rv,
    output logic [NRP-1:0]       rs_busy,
    input  logic [NWP-1:0]       we,
    input  logic [NWP*$clog2(NREGS)-1:0] rd,
    input  logic [NWP*XLEN-1:0]  wdata,
    input  logic [NWP-1:0]       wb_clr,
    input  logic                 iss_valid,
    input  logic [$clog2(NREGS)-1:0] iss_rd,
    output logic                 any_busy
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == AW'(ZERO_ADDR));
    endfunction

    // ascending port order lets the youngest port win a conflict
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWP; j++) begin
            if (we[j] && !is_zero(rd[j*AW +: AW])) begin
                regs_d[rd[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rv = '0;
        for (int k = 0; k < NRP; k++) begin
            if (!is_zero(rs[k*AW +: AW])) begin
                rv[k*XLEN +: XLEN] = regs_q[rs[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWP; j++) begin
                    if (we[j] && (rd[j*AW +: AW] == rs[k*AW +: AW])) begin
                        rv[k*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
                    end
                end
`endif
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .NRP      (NRP),
        .NWP      (NWP),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .rs        (rs),
        .wb_clr    (wb_clr),
        .rd        (rd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs_busy   (rs_busy),
        .any_busy  (any_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rs;
    logic [63:0] rv;
    logic [1:0]  rs_busy;
    logic [1:0]  we;
    logic [9:0]  rd;
    logic [63:0] wdata;
    logic [1:0]  wb_clr;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        any_busy;

    int compared   = 0;
    int mismatched = 0;

    regfile_mp dut (
        .clk       (clk),
        .reset     (reset),
        .rs        (rs),
        .rv        (rv),
        .rs_busy   (rs_busy),
        .we        (we),
        .rd        (rd),
        .wdata     (wdata),
        .wb_clr    (wb_clr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .any_busy  (any_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we = '0; rd = '0; wdata = '0;
        wb_clr = '0; iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        rs = '0;
        idle();
        tick();
        tick();
        reset = 1'b1;
        rs = {5'd1, 5'd5};
        #1;
        chk("rst_rv0", rv[31:0], 32'h0);
        chk("rst_busy", {30'd0, rs_busy}, 32'h0);
        chk("rst_any", {31'd0, any_busy}, 32'h0);

        // x5 written and pending, then reset for one cycle
        we = 2'b01; rd = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEAD_BEEF};
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        idle();
        #1;
        chk("x5_val", rv[31:0], 32'hDEAD_BEEF);
        chk("x5_busy", {31'd0, rs_busy[0]}, 32'h1);
        chk("x5_any", {31'd0, any_busy}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("rst2_rv", rv[31:0], 32'h0);
        chk("rst2_busy", {31'd0, rs_busy[0]}, 32'h0);
        chk("rst2_any", {31'd0, any_busy}, 32'h0);

        // zero register ignores writes and issues
        we = 2'b01; rd = '0; wdata = {32'h0, 32'h1234};
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        idle();
        rs = {5'd0, 5'd0};
        #1;
        chk("x0_val", rv[31:0], 32'h0);
        chk("x0_busy", {31'd0, rs_busy[0]}, 32'h0);
        chk("x0_any", {31'd0, any_busy}, 32'h0);

        // write conflict: youngest port wins
        we = 2'b11; rd = {5'd7, 5'd7}; wdata = {32'h2, 32'h1};
        tick();
        idle();
        rs = {5'd7, 5'd7};
        #1;
        chk("conf_p0", rv[31:0], 32'h2);
        chk("conf_p1", rv[63:32], 32'h2);

        // independent writes on both ports, read on both ports
        we = 2'b11; rd = {5'd11, 5'd8};
        wdata = {32'h0BAD_F00D, 32'h8888_0008};
        tick();
        idle();
        rs = {5'd8, 5'd11};
        #1;
        chk("w_x11_p0", rv[31:0], 32'h0BAD_F00D);
        chk("w_x8_p1", rv[63:32], 32'h8888_0008);

        // scoreboard: set, set+clear (set wins), clear
        rs = {5'd3, 5'd0};
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        idle();
        #1;
        chk("sb_n1", {31'd0, rs_busy[1]}, 32'h1);
        tick();
        tick();
        tick();
        chk("sb_n4", {31'd0, rs_busy[1]}, 32'h1);
        iss_valid = 1'b1; iss_rd = 5'd3;
        wb_clr = 2'b01; rd = {5'd0, 5'd3};
        #1;
        chk("sb_setclr_now", {31'd0, rs_busy[1]}, 32'h1);
        tick();
        idle();
        #1;
        chk("sb_n5", {31'd0, rs_busy[1]}, 32'h1);
        wb_clr = 2'b01; rd = {5'd0, 5'd3};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("sb_clr_now", {31'd0, rs_busy[1]}, 32'h0);
`else
        chk("sb_clr_now", {31'd0, rs_busy[1]}, 32'h1);
`endif
        tick();
        idle();
        #1;
        chk("sb_n6", {31'd0, rs_busy[1]}, 32'h0);
        chk("sb_n6_any", {31'd0, any_busy}, 32'h0);

        // clear through write port 1; clear of idle reg is a no-op
        iss_valid = 1'b1; iss_rd = 5'd12;
        rs = {5'd12, 5'd12};
        tick();
        idle();
        #1;
        chk("sb12_set", {30'd0, rs_busy}, 32'h3);
        wb_clr = 2'b11; rd = {5'd12, 5'd20};
        tick();
        idle();
        #1;
        chk("sb12_clr", {30'd0, rs_busy}, 32'h0);
        chk("sb12_any", {31'd0, any_busy}, 32'h0);

        // same-cycle read of a register being written
        we = 2'b01; rd = {5'd0, 5'd9}; wdata = {32'h0, 32'h5};
        tick();
        idle();
        rs = {5'd0, 5'd9};
        we = 2'b10; rd = {5'd9, 5'd0}; wdata = {32'hCAFE_0001, 32'h0};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("raw_now", rv[31:0], 32'hCAFE_0001);
`else
        chk("raw_now", rv[31:0], 32'h5);
`endif
        tick();
        idle();
        #1;
        chk("raw_next", rv[31:0], 32'hCAFE_0001);

        // reset overrides write and issue in the same cycle
        we = 2'b01; rd = {5'd0, 5'd4}; wdata = {32'h0, 32'h77};
        iss_valid = 1'b1; iss_rd = 5'd4;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle();
        rs = {5'd9, 5'd4};
        #1;
        chk("rstw_x4", rv[31:0], 32'h0);
        chk("rstw_busy", {31'd0, rs_busy[0]}, 32'h0);
        chk("rstw_x9", rv[63:32], 32'h0);
        chk("rstw_any", {31'd0, any_busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the CPU: NRP asynchronous read ports, NWP synchronous write ports, plus a per-register pending (scoreboard) bit array.
- Successor to the single-write, dual-read register file; serves the dual-issue pipeline.
- Decode uses the pending bits to stall on RAW hazards; writeback clears them.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >=2).
- AW, $clog2(NREGS), address width (localparam, not overridable).
- NRP, 2, number of read ports (1..4).
- NWP, 2, number of write ports (1..2); port NWP-1 is the youngest.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- rs  in  NRP*AW  read addresses, port k at [k*AW +: AW].
- rv  out  NRP*XLEN  read data, port k at [k*XLEN +: XLEN].
- rs_busy  out  NRP  pending bit of the register addressed by rs port k.
- we  in  NWP  write enable per write port.
- rd  in  NWP*AW  write addresses.
- wdata  in  NWP*XLEN  write data.
- wb_clr  in  NWP  clear the pending bit of rd[j] (writeback retire); independent of we.
- iss_valid  in  1  issue: set the pending bit of iss_rd.
- iss_rd  in  AW  destination of the issuing instruction.
- any_busy  out  1  OR of all pending bits (pipeline drain/flush check).

Behaviour:
- Reset (reset==0 at posedge):
  - All registers become 0; all pending bits become 0.
  - Overrides every we/wb_clr/iss_valid in that cycle.
  - After reset, rv = 0, rs_busy = 0, any_busy = 0.
- Read: combinational. rv[k] = reg[rs[k]]; rs_busy[k] = pend[rs[k]]. Zero latency, no handshake.
- Write: at posedge, for each j with we[j], reg[rd[j]] <= wdata[j].
  - Same-cycle write conflict (we[0] && we[1] && rd[0]==rd[1]): port NWP-1 wins.
- Zero register: with ZERO_REG=1, writes, issues and clears to address 0 are ignored; reg[0] reads 0 and pend[0] reads 0.
- Scoreboard, per register r, next state:
  - Set term: iss_valid && iss_rd==r.
  - Clear term: any j with wb_clr[j] && rd[j]==r.
  - Set wins over clear in the same cycle, because the issuing instruction is younger than the retiring one.
  - Setting an already-pending register keeps it pending; there is no counter.
  - Clearing a non-pending register is legal and a no-op.
- Read-after-write in the same cycle: the read returns the old value unless REGFILE_BYPASS_EN is defined.
- Read/write timing: read ports sample the array continuously, so a posedge write is visible on rv in the following cycle.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - Write-through forwarding. If we[j] && rd[j]==rs[k] (and not the zero register), rv[k] = wdata[j] in the same cycle; the highest j wins.
  - rs_busy[k] also reads 0 when wb_clr[j] && rd[j]==rs[k] and there is no same-cycle issue to that register.
  - Decode can therefore consume the writeback result without a bubble.
- Not defined: pure array read with no forwarding; one extra stall cycle on a writeback-to-decode RAW.

Decomposition:
- Shared package regfile_pkg:
  - Default XLEN/NREGS constants.
  - Typedef reg_addr_t (logic [AW-1:0]) and xword_t (logic [XLEN-1:0]).
  - Constant ZERO_ADDR.
- One natural sub-module: regfile_scoreboard, holding the NREGS pending bits, the set/clear priority, any_busy and the rs_busy lookup. The data array and forwarding muxes stay in regfile_mp.

Test Plan:
- Reset with x5 = 32'hDEAD_BEEF and x5 pending, reset low for 1 cycle -> next cycle rv(x5)=0, rs_busy=0, any_busy=0.
- we[0]=1, rd[0]=0, wdata=32'h1234 with ZERO_REG=1 -> rv(rs=0)=0; iss_valid, iss_rd=0 -> rs_busy=0.
- we[0]=we[1]=1, rd=7 on both, wdata[0]=32'h1, wdata[1]=32'h2 -> next cycle rv(x7)=32'h2.
- Cycle N: iss_valid, iss_rd=3 -> rs_busy(x3)=1 from N+1. Cycle N+4: iss_valid, iss_rd=3, plus wb_clr[0], rd[0]=3 -> x3 remains pending. Cycle N+5: wb_clr only -> rs_busy=0 at N+6.
- Same-cycle read: rs[0]=9, we[1]=1, rd[1]=9, wdata=32'hCAFE_0001, old x9=32'h5:
  - With REGFILE_BYPASS_EN: rv[0]=32'hCAFE_0001 that cycle.
  - Without it: rv[0]=32'h5, then 32'hCAFE_0001 next cycle.
- Reset asserted in the same cycle as we=1, rd=4 and iss_valid, iss_rd=4 -> x4 stays 0 and is not pending.
